// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, in-order request issue, response buffer, redirect flush/drop.
// Optional IFETCH_MISALIGN_TRAP_EN adds if_fault for misaligned redirect targets.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   instr_fetch_if.master       imem,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   output logic                if_valid,
   input  logic                if_ready,
   output logic [31:0]         if_instr,
   output logic [31:0]         if_pc
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                if_fault
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   pc, tgt, rsp_pc, wr_pc, wr_instr;
   logic          run, halt, fault_pend, misal;
   logic [CW-1:0] outst, count;
   logic [AW-1:0] head, tail;
   logic [7:0]    drop;
   logic          grant, pop, live_resp, drop_resp, push;
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc    [DEPTH];

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic          fifo_fault [DEPTH];
   assign misal = |redirect_pc[1:0];
   assign tgt   = redirect_pc;
`else
   assign misal = 1'b0;
   assign tgt   = redirect_pc & 32'hFFFF_FFFC;
`endif

   assign if_valid  = (count != '0);
   assign pop       = if_valid & if_ready;
   // Live outstanding + occupancy bounds issue, so every live response has a slot.
   assign imem.imem_req  = run & ~halt & ~fault_pend &
                           ((int'(outst) + int'(count) - int'(pop)) < DEPTH);
   assign imem.imem_addr = pc & 32'hFFFF_FFFC;
   assign grant     = imem.imem_req & imem.imem_gnt;
   assign live_resp = imem.imem_rvalid & (drop == 8'd0);
   assign drop_resp = imem.imem_rvalid & (drop != 8'd0);
   assign push      = ~redirect_valid & (live_resp | fault_pend);
   // Live requests are consecutive words ending just below pc; oldest is pc - 4*outst.
   assign rsp_pc    = pc - (32'(outst) << 2);
   assign wr_pc     = fault_pend ? pc : rsp_pc;
   assign wr_instr  = fault_pend ? 32'd0 : imem.imem_rdata;

   assign if_instr  = if_valid ? fifo_instr[head] : 32'd0;
   assign if_pc     = if_valid ? fifo_pc[head]    : 32'd0;
`ifdef IFETCH_MISALIGN_TRAP_EN
   assign if_fault  = if_valid & fifo_fault[head];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         run        <= 1'b0;
         halt       <= 1'b0;
         fault_pend <= 1'b0;
         outst      <= '0;
         count      <= '0;
         head       <= '0;
         tail       <= '0;
         drop       <= '0;
      end else begin
         run <= 1'b1;
         if (redirect_valid) begin
            // Everything still in flight, including this cycle's grant, becomes a drop.
            pc         <= tgt;
            outst      <= '0;
            count      <= '0;
            head       <= '0;
            tail       <= '0;
            drop       <= drop - 8'(drop_resp) + 8'(outst) + 8'(grant) - 8'(live_resp);
            halt       <= misal;
            fault_pend <= misal;
         end else begin
            if (grant) pc <= pc + 32'd4;
            outst      <= outst + CW'(grant) - CW'(live_resp);
            drop       <= drop - 8'(drop_resp);
            count      <= count + CW'(push) - CW'(pop);
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            fault_pend <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[tail] <= wr_instr;
         fifo_pc[tail]    <= wr_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
         fifo_fault[tail] <= fault_pend;
`endif
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch with an in-order memory model and a queue-level fetch model.
module tb_instr_fetch;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid, if_valid, if_ready;
   logic [31:0] redirect_pc, if_instr, if_pc;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic        if_fault;
`endif

   always #5 clk = ~clk;

   instr_fetch_if imem ();

   instr_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .imem(imem),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef IFETCH_MISALIGN_TRAP_EN
      , .if_fault(if_fault)
`endif
   );

   typedef struct { logic [31:0] addr; bit stale; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; bit fault; } ent_t;

   mreq_t       mq[$];   // requests accepted by memory, oldest first
   ent_t        mb[$];   // instructions the fetch buffer must hold, oldest first
   logic [31:0] mpc;
   bit          started, halt, fpend;
   int          cyc, n_cmp, n_bad, drops, grants;
   int          lat_min = 1, lat_max = 1;
   bit          last_req, last_valid, last_rv, last_fault;
   logic [31:0] last_addr, last_pc, last_instr;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      mq.delete(); mb.delete();
      mpc = 32'h0; started = 0; halt = 0; fpend = 0;
   endtask

   task automatic step(input bit rdr, input logic [31:0] tgt, input bit rdy, input bit g);
      bit rv, pop, ereq, grant;
      int live, occ;
      mreq_t e;
      @(negedge clk);
      redirect_valid = rdr; redirect_pc = tgt; if_ready = rdy; imem.imem_gnt = g;
      rv = (mq.size() > 0) && (mq[0].due <= cyc);
      imem.imem_rvalid = rv;
      imem.imem_rdata  = rv ? mem(mq[0].addr) : $urandom;
      #1;
      last_req = imem.imem_req; last_addr = imem.imem_addr; last_valid = if_valid;
      last_pc = if_pc; last_instr = if_instr; last_rv = rv;
`ifdef IFETCH_MISALIGN_TRAP_EN
      last_fault = if_fault;
`else
      last_fault = 0;
`endif
      if (!rst_n) begin
         chk("rst_req", imem.imem_req, 0);
         chk("rst_addr", imem.imem_addr, 32'h0);
         chk("rst_valid", if_valid, 0);
         chk("rst_instr", if_instr, 0);
         chk("rst_pc", if_pc, 0);
      end else begin
         live = 0;
         foreach (mq[i]) if (!mq[i].stale) live++;
         occ  = mb.size();
         pop  = (occ > 0) && rdy;
         ereq = started && !halt && !fpend && (live + occ - int'(pop) < DEPTH);
         chk("imem_req", imem.imem_req, ereq);
         if (ereq) chk("imem_addr", imem.imem_addr, {mpc[31:2], 2'b00});
         chk("if_valid", if_valid, occ > 0);
         if (occ > 0) begin
            chk("if_pc", if_pc, mb[0].pc);
            chk("if_instr", if_instr, mb[0].instr);
`ifdef IFETCH_MISALIGN_TRAP_EN
            chk("if_fault", if_fault, mb[0].fault);
`endif
         end
         // what the coming rising edge must do
         grant = ereq && g;
         if (pop) void'(mb.pop_front());
         if (rv) begin
            e = mq.pop_front();
            if (e.stale) drops++;
            else if (!rdr) mb.push_back('{e.addr, mem(e.addr), 1'b0});
         end
         if (grant) begin
            grants++;
            mq.push_back('{{mpc[31:2], 2'b00}, rdr, cyc + int'($urandom_range(lat_min, lat_max))});
         end
         if (rdr) begin
            foreach (mq[i]) mq[i].stale = 1;
            mb.delete();
`ifdef IFETCH_MISALIGN_TRAP_EN
            mpc = tgt;
            halt = (tgt[1:0] != 2'b00);
            fpend = halt;
`else
            mpc = {tgt[31:2], 2'b00};
`endif
         end else begin
            if (grant) mpc += 32'd4;
            if (fpend) begin
               mb.push_back('{mpc, 32'h0, 1'b1});
               fpend = 0;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      model_clear();
      repeat (n) step(0, 32'h0, 0, 0);
      rst_n = 1'b1;
      started = 1;
   endtask

   initial begin
      bit found;
      int d0, g0;
      logic [31:0] t;
      redirect_valid = 0; redirect_pc = 0; if_ready = 0;
      imem.imem_gnt = 0; imem.imem_rvalid = 0; imem.imem_rdata = 0;
      do_reset(3);

      // streaming from reset with single-cycle memory
      for (int k = 0; k < 3; k++) begin
         step(0, 32'h0, 1, 1);
         chk("a_req", last_req, 1);
         chk("a_addr", last_addr, 32'(4 * k));
      end
      chk("a_first_valid", last_valid, 1);
      chk("a_first_pc", last_pc, 32'h0);
      for (int k = 0; k < 15; k++) begin
         step(0, 32'h0, 1, 1);
         chk("a_zero_bubble", last_valid, 1);
      end

      // downstream stall fills the buffer, then drains in order
      do_reset(2);
      g0 = grants;
      repeat (10) step(0, 32'h0, 0, 1);
      chk("b_grants", grants - g0, DEPTH);
      chk("b_req_off", last_req, 0);
      chk("b_full_valid", last_valid, 1);
      repeat (20) step(0, 32'h0, 1, 1);

      // redirect with two requests outstanding
      do_reset(2);
      lat_min = 4; lat_max = 4;
      d0 = drops;
      step(0, 32'h0, 1, 1);
      step(0, 32'h0, 1, 1);
      step(1, 32'h100, 1, 1);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         step(0, 32'h0, 1, 1);
         if (last_valid) begin
            found = 1;
            chk("c_first_pc", last_pc, 32'h100);
         end
      end
      if (!found) chk("c_valid_timeout", 0, 1);
      chk("c_drops", drops - d0, 2);

      // redirect colliding with grant, response and pop
      lat_min = 1; lat_max = 1;
      repeat (10) step(0, 32'h0, 1, 1);
      d0 = drops;
      step(1, 32'h300, 1, 1);
      chk("d_pre_req", last_req, 1);
      chk("d_pre_rv", last_rv, 1);
      chk("d_pre_valid", last_valid, 1);
      step(0, 32'h0, 1, 1);
      chk("d_flushed", last_valid, 0);
      chk("d_addr", last_addr, 32'h300);
      chk("d_req", last_req, 1);
      repeat (4) step(0, 32'h0, 1, 1);
      chk("d_drops", drops - d0, 1);

      // misaligned redirect target
      step(1, 32'h102, 1, 1);
`ifdef IFETCH_MISALIGN_TRAP_EN
      found = 0;
      for (int k = 0; k < 10 && !found; k++) begin
         step(0, 32'h0, 1, 1);
         if (last_valid) begin
            found = 1;
            chk("e_fault_pc", last_pc, 32'h102);
            chk("e_fault", last_fault, 1);
         end
      end
      if (!found) chk("e_fault_timeout", 0, 1);
      for (int k = 0; k < 5; k++) begin
         step(0, 32'h0, 1, 1);
         chk("e_halt_req", last_req, 0);
      end
      step(1, 32'h200, 1, 1);
      step(0, 32'h0, 1, 1);
      chk("e_resume_req", last_req, 1);
      chk("e_resume_addr", last_addr, 32'h200);
`else
      step(0, 32'h0, 1, 1);
      chk("e_req", last_req, 1);
      chk("e_addr", last_addr, 32'h100);
`endif

      // randomized traffic
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset(2);
         else begin
            t = $urandom & 32'h0000_FFFC;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
`else
            t[1:0] = 2'($urandom_range(0, 3));
`endif
            step($urandom_range(0, 99) < 3, t, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 75);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, sets the instruction buffer entries and the outstanding-request limit; legal values are powers of two, 2 to 8.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 imem_req  out  1  fetch request to instruction memory.
REQ-006 imem_addr  out  32  fetch address, word aligned.
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid; responses return in order.
REQ-009 imem_rdata  in  32  returned instruction word.
REQ-010 redirect_valid  in  1  branch, jump or trap redirect from execute.
REQ-011 redirect_pc  in  32  redirect target address.
REQ-012 if_valid  out  1  if_instr and if_pc are valid to decode and immgen.
REQ-013 if_ready  in  1  downstream accepts the instruction.
REQ-014 if_instr  out  32  fetched instruction word.
REQ-015 if_pc  out  32  address of if_instr.

Function
REQ-016 The block SHALL hold a fetch PC register; imem_addr = PC; PC += 4 on each cycle where imem_req && imem_gnt && !redirect_valid.
REQ-017 The block SHALL assert imem_req only while (outstanding + buffer occupancy) < DEPTH, so every response has a guaranteed buffer slot.
REQ-018 Once asserted, imem_req and imem_addr SHALL remain stable until imem_gnt, except on redirect.
REQ-019 Each accepted response SHALL be written to the buffer tail with its PC; buffer order equals request order.
REQ-020 if_valid = buffer not empty; if_instr and if_pc come from the buffer head; the head is popped on if_valid && if_ready.
REQ-021 A response and a pop in the same cycle SHALL both take effect; when full, a pop frees a slot and imem_req may assert that cycle.
REQ-022 On redirect_valid the block SHALL flush the buffer, set PC = redirect_pc, and set a drop counter to the number of outstanding requests, including one granted in the same cycle.
REQ-023 While the drop counter is nonzero, each imem_rvalid SHALL decrement it and the data SHALL be discarded.
REQ-024 New requests SHALL issue at the redirect target starting the cycle after redirect, in parallel with the draining drops.
REQ-025 Redirect SHALL take priority over simultaneous grant, response and pop; if_valid SHALL be 0 the cycle after redirect.
REQ-026 Back-to-back redirects SHALL each apply fully; the last one wins the PC.
REQ-027 Fetch SHALL be zero-bubble: with single-cycle memory and if_ready high, one instruction per cycle is sustained.

Reset
REQ-028 While rst_n = 0: PC = RESET_PC, imem_req = 0, if_valid = 0, buffer empty, outstanding = 0, drop counter = 0, if_instr = 0, if_pc = 0.
REQ-029 imem_req SHALL first assert on the first rising edge after rst_n deasserts. Reset mid-transaction SHALL abandon all in-flight responses; the memory is reset together with this block.

Configuration
REQ-030 With IFETCH_MISALIGN_TRAP_EN defined, the block SHALL add output if_fault (1 bit). A redirect_pc with bits [1:0] != 0 SHALL produce one buffer entry with if_fault = 1 and if_pc = redirect_pc, and SHALL stop fetching until the next redirect.
REQ-031 Without IFETCH_MISALIGN_TRAP_EN, if_fault is absent and redirect_pc[1:0] is ignored (forced to 0).

Verification
REQ-032 Reset release, 1-cycle memory, if_ready = 1 -> addresses 0x0, 0x4, 0x8 on consecutive cycles; if_valid continuous from cycle 2.
REQ-033 if_ready = 0 for 10 cycles -> at most DEPTH = 2 requests issued, buffer full, imem_req = 0; if_ready = 1 -> the PC sequence resumes with no loss or duplication.
REQ-034 Redirect to 0x100 with 2 requests outstanding -> the next 2 rvalids are dropped; the first if_pc after redirect is 0x100.
REQ-035 Redirect in the same cycle as grant, rvalid and pop -> buffer empty next cycle, drop counter = outstanding + 1, imem_addr = target.
REQ-036 With the macro: redirect to 0x102 -> one entry with if_fault = 1 and if_pc = 0x102, then imem_req = 0 until redirect to 0x200. Without the macro: fetch starts at 0x100.
